msg_schedule: RTL

- Parametrised SHA-2 message-schedule expander.
- Accepts one 16-word message block over a valid/ready load interface and buffers it in a 16-entry circular register file.
- Streams W[0..ROUNDS-1] to the round engine over a valid/ready output with back-pressure.
- Supports SHA-256 (32-bit words) and SHA-512 (64-bit words), selected by DATA_WIDTH. Sits between the padder and the compression core.

---
 rtl/sha2_pkg.sv | 33 +++
 rtl/msg_schedule_if.sv | 28 ++
 rtl/sha2_sigma_lower.sv | 23 ++
 rtl/msg_schedule.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/sha2_pkg.sv
// Shared SHA-2 constants and types for the message-schedule expander.
// Holds round counts, sigma rotate/shift amounts and the FSM state type.
package sha2_pkg;

    localparam int ROUNDS_256 = 64;
    localparam int ROUNDS_512 = 80;
    localparam int IDX_W      = 7;

    localparam int SIG0_R1_256 = 7;
    localparam int SIG0_R2_256 = 18;
    localparam int SIG0_SH_256 = 3;
    localparam int SIG1_R1_256 = 17;
    localparam int SIG1_R2_256 = 19;
    localparam int SIG1_SH_256 = 10;

    localparam int SIG0_R1_512 = 1;
    localparam int SIG0_R2_512 = 8;
    localparam int SIG0_SH_512 = 7;
    localparam int SIG1_R1_512 = 19;
    localparam int SIG1_R2_512 = 61;
    localparam int SIG1_SH_512 = 6;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_EXPAND = 2'd2
    } state_t;

    function automatic int rounds_for(input int data_width);
        return (data_width == 64) ? ROUNDS_512 : ROUNDS_256;
    endfunction

endpackage

// File: rtl/msg_schedule_if.sv
// Load and schedule-stream handshake bundle of the message-schedule expander.
// master = padder/round-engine side, slave = the expander.
interface msg_schedule_if
    import sha2_pkg::*;
#(
    parameter int DATA_WIDTH = 32
);
    logic                  start;
    logic                  word_valid;
    logic [DATA_WIDTH-1:0] word;
    logic                  word_ready;
    logic                  w_valid;
    logic [DATA_WIDTH-1:0] w;
    logic [IDX_W-1:0]      w_idx;
    logic                  w_ready;
    logic                  busy;
    logic                  done;

    modport master (
        output start, word_valid, word, w_ready,
        input  word_ready, w_valid, w, w_idx, busy, done
    );

    modport slave (
        input  start, word_valid, word, w_ready,
        output word_ready, w_valid, w, w_idx, busy, done
    );
endinterface

// File: rtl/sha2_sigma_lower.sv
// SHA-2 small sigma function: SEL=0 gives sig0, SEL=1 gives sig1,
// with rotate/shift amounts picked by word width.
module sha2_sigma_lower
    import sha2_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int SEL        = 0
) (
    input  logic [DATA_WIDTH-1:0] x,
    output logic [DATA_WIDTH-1:0] y
);
    localparam bit WIDE = (DATA_WIDTH == 64);
    localparam int R1 = WIDE ? ((SEL != 0) ? SIG1_R1_512 : SIG0_R1_512)
                             : ((SEL != 0) ? SIG1_R1_256 : SIG0_R1_256);
    localparam int R2 = WIDE ? ((SEL != 0) ? SIG1_R2_512 : SIG0_R2_512)
                             : ((SEL != 0) ? SIG1_R2_256 : SIG0_R2_256);
    localparam int SH = WIDE ? ((SEL != 0) ? SIG1_SH_512 : SIG0_SH_512)
                             : ((SEL != 0) ? SIG1_SH_256 : SIG0_SH_256);

    assign y = ((x >> R1) | (x << (DATA_WIDTH - R1)))
             ^ ((x >> R2) | (x << (DATA_WIDTH - R2)))
             ^ (x >> SH);
endmodule

// File: rtl/msg_schedule.sv
// SHA-2 message-schedule expander: loads a 16-word block into a circular
// register file, then streams W[0..ROUNDS-1] with valid/ready back-pressure.
module msg_schedule
    import sha2_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    msg_schedule_if.slave bus
);
    localparam int ROUNDS = rounds_for(DATA_WIDTH);

    generate
        if ((DATA_WIDTH != 32) && (DATA_WIDTH != 64)) begin : g_bad_width
            $error("msg_schedule: DATA_WIDTH must be 32 or 64");
        end
    endgenerate

    state_t                state_reg;
    state_t                state_next;
    logic [3:0]            cnt_reg;
    logic [IDX_W-1:0]      idx_reg;
    logic [DATA_WIDTH-1:0] w_reg;
    logic                  valid_reg;
    logic                  done_reg;
    logic [DATA_WIDTH-1:0] buf_mem [16];

    logic                  load_fire;
    logic                  load_last;
    logic                  advance;
    logic                  last_round;
    logic [IDX_W-1:0]      t_next;
    logic [3:0]            t_lo;
    logic                  t_expand;
    logic                  exp_wr;
    logic [DATA_WIDTH-1:0] sig0_w;
    logic [DATA_WIDTH-1:0] sig1_w;
    logic [DATA_WIDTH-1:0] w_new;
    logic [DATA_WIDTH-1:0] w_next;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [15:0]           wr_en;

    assign load_fire  = (state_reg == ST_LOAD) && bus.word_valid;
    assign load_last  = load_fire && (cnt_reg == 4'd15);
    assign advance    = (state_reg == ST_EXPAND) && valid_reg && bus.w_ready;
    assign last_round = (idx_reg == IDX_W'(ROUNDS - 1));
    assign t_next     = idx_reg + IDX_W'(1);
    assign t_lo       = t_next[3:0];
    assign t_expand   = (t_next[IDX_W-1:4] != '0);
    assign exp_wr     = advance && !last_round && t_expand;

    // t-15 and t+1 alias to the same slot in a 16-entry ring.
    sha2_sigma_lower #(.DATA_WIDTH(DATA_WIDTH), .SEL(0)) u_sig0 (
        .x (buf_mem[t_lo + 4'd1]),
        .y (sig0_w)
    );

    sha2_sigma_lower #(.DATA_WIDTH(DATA_WIDTH), .SEL(1)) u_sig1 (
        .x (buf_mem[t_lo - 4'd2]),
        .y (sig1_w)
    );

    assign w_new   = sig1_w + buf_mem[t_lo - 4'd7] + sig0_w + buf_mem[t_lo];
    assign w_next  = t_expand ? w_new : buf_mem[t_lo];
    assign wr_data = load_fire ? bus.word : w_new;

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_wr_en
            assign wr_en[gi] = (load_fire && (cnt_reg == 4'(gi)))
                            || (exp_wr && (t_lo == 4'(gi)));
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < 16; i++) begin
            if (wr_en[i]) begin
                buf_mem[i] <= wr_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (bus.start)               state_next = ST_LOAD;
            ST_LOAD:   if (load_last)               state_next = ST_EXPAND;
            ST_EXPAND: if (advance && last_round)   state_next = ST_IDLE;
            default:                                state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.word_ready = (state_reg == ST_LOAD);
        bus.busy       = (state_reg != ST_IDLE);
        bus.w_valid    = valid_reg;
        bus.w          = w_reg;
        bus.w_idx      = idx_reg;
        bus.done       = done_reg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg   <= '0;
            idx_reg   <= '0;
            w_reg     <= '0;
            valid_reg <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= advance && last_round;
            if (state_reg == ST_IDLE) begin
                cnt_reg <= '0;
            end else if (load_fire) begin
                cnt_reg <= cnt_reg + 4'd1;
            end
            // W[0] is already in slot 0 when the 16th word lands in slot 15.
            if (load_last) begin
                valid_reg <= 1'b1;
                idx_reg   <= '0;
                w_reg     <= buf_mem[0];
            end else if (advance) begin
                if (last_round) begin
                    valid_reg <= 1'b0;
                    idx_reg   <= '0;
                end else begin
                    idx_reg <= t_next;
                    w_reg   <= w_next;
                end
            end
        end
    end

    a_hold_stable: assert property (@(posedge clk) disable iff (rst)
        (bus.w_valid && !bus.w_ready) |=> ($stable(bus.w) && $stable(bus.w_idx) && bus.w_valid));
    a_done_pulse: assert property (@(posedge clk) disable iff (rst)
        bus.done |=> !bus.done);
    a_exclusive: assert property (@(posedge clk)
        !(bus.word_ready && bus.w_valid));

endmodule
